lut_multiplier_seq_ctrl: RTL and testbench
==========================================

// Module: lut_multiplier_seq_ctrl
// PURPOSE
//  Sequencer for one lut_multiplier_4b_cond datapath instance. Computes a 32x32 unsigned product over
//  successive clocks, one 4-bit digit of the multiplier per cycle, accumulating shifted partials.
//  Sits between a requester (valid/ready start handshake) and the consumer (valid/ready result).
// PARAMETERS
//  OPER_W    32  operand width; fixed, must be a multiple of DIGIT_W
//  DIGIT_W   4   digit width consumed per cycle (matches the 4b LUT multiplier)
//  N_DIGITS  8   OPER_W/DIGIT_W, derived localparam, not overridable
// PORTS
//  clk_seq         in   1   single clock, all state on rising edge
//  reset_seq       in   1   synchronous, active-high reset
//  start_valid     in   1   requester presents operands
//  start_ready     out  1   high only in IDLE; accept = start_valid & start_ready
//  operand_a       in   32  multiplicand, sampled on accept
//  operand_b       in   32  multiplier, sampled on accept
//  busy            out  1   high in RUN or DONE
//  result_valid    out  1   high in DONE
//  result_ready    in   1   consumer takes result when result_valid & result_ready
//  result          out  64  product, stable while result_valid
// BEHAVIOUR
//  Reset (sync, active-high): state IDLE, acc=0, digit_cnt=0, start_ready=1, busy=0, result_valid=0, result=0.
//  Reset mid-operation: same; operation discarded, no result produced.
//  FSM IDLE -> RUN on accept: latch a_reg=operand_a, b_reg=operand_b, acc=0, digit_cnt=0.
//  RUN: partial = a_reg * b_reg[3:0] (from the 4b LUT instance, its upper digit input tied to 0,
//       resetn driven by ~reset_seq); acc += partial << (4*digit_cnt); b_reg >>= 4; digit_cnt++.
//       After digit_cnt==N_DIGITS-1 is processed -> DONE.
//  DONE: result=acc, result_valid=1; held until result_ready; handshake -> IDLE (start_ready=1 the next cycle).
//  Latency: result_valid rises on the 8th rising edge after the accept edge; throughput one op per >=10 cycles.
//  Arithmetic: unsigned; partial 36b zero-extended to 64b; acc cannot overflow (max 0xFFFFFFFE00000001).
//  start_valid in RUN/DONE: ignored, operands not resampled; requester must hold until accepted.
//  result_ready while not result_valid: no effect. Operand changes after accept: no effect.
// CONFIGURATION
//  EARLY_TERM_EN defined: in RUN, if the shifted b_reg (after the current digit) is all zero, go to
//    DONE after this cycle; cycles in RUN = index of highest nonzero digit + 1, minimum 1 (b=0 -> 1).
//  EARLY_TERM_EN undefined: always exactly N_DIGITS RUN cycles regardless of operand_b.
//  Product value identical in both builds.
// STRUCTURE
//  Shared header lut_mult_defs.vh: OPER_W, DIGIT_W, N_DIGITS, state encodings ST_IDLE/ST_RUN/ST_DONE (2b).
//  One sub-module: lut_multiplier_4b_cond (existing), instantiated once as the datapath;
//  the controller owns registers, accumulator, shifter and FSM in this file.
// TESTING
//  1 Reset held 3 cycles, random inputs -> start_ready=1, busy=0, result_valid=0, result=0.
//  2 a=0xFFFFFFFF b=0xFFFFFFFF, result_ready=1 -> result=0xFFFFFFFE00000001, valid 8 edges after accept
//    (both builds, all digits nonzero).
//  3 a=3 b=5 -> result=15; valid 8 edges after accept without EARLY_TERM_EN, 1 edge with it.
//  4 a=0x12345678 b=0x00010000 -> result=0x0000123456780000; with EARLY_TERM_EN RUN lasts 5 cycles.
//  5 start_valid pulsed with new operands during RUN -> ignored, first product unchanged, start_ready=0.
//  6 reset_seq asserted on RUN cycle 4 -> IDLE next edge, no result_valid; new op a=7 b=6 -> 42.
//  7 result_ready low 5 cycles in DONE -> result_valid and result held stable; IDLE one cycle after ready.

Source files
------------

// File: rtl/lut_multiplier_seq_ctrl_pkg.sv
// Shared widths and FSM encoding for the digit-serial 32x32 LUT multiplier sequencer.
package lut_multiplier_seq_ctrl_pkg;

    localparam int unsigned OPER_W   = 32;
    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned N_DIGITS = OPER_W / DIGIT_W;
    localparam int unsigned CNT_W    = $clog2(N_DIGITS);
    localparam int unsigned PROD_W   = 2 * OPER_W;
    localparam int unsigned PART_W   = OPER_W + 2 * DIGIT_W;
    localparam int unsigned SH_W     = $clog2(PROD_W);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/lut_multiplier_4b_cond.sv
// Multiplicand times an 8-bit (two-digit) multiplier from a 16-entry multiple table;
// output forced to zero while resetn is low.
module lut_multiplier_4b_cond
    import lut_multiplier_seq_ctrl_pkg::*;
(
    input  logic                resetn,
    input  logic [OPER_W-1:0]   mcand,
    input  logic [DIGIT_W-1:0]  digit_lo,
    input  logic [DIGIT_W-1:0]  digit_hi,
    output logic [PART_W-1:0]   product
);

    localparam int unsigned TBL_W = OPER_W + DIGIT_W;

    logic [TBL_W-1:0] mult_tbl [2**DIGIT_W];

    // Entry i holds i * mcand, built by repeated addition.
    always_comb begin
        mult_tbl[0] = '0;
        for (int i = 1; i < 2**DIGIT_W; i++) begin
            mult_tbl[i] = mult_tbl[i-1] + TBL_W'(mcand);
        end
    end

    always_comb begin
        product = '0;
        if (resetn) begin
            product = PART_W'(mult_tbl[digit_lo])
                    + (PART_W'(mult_tbl[digit_hi]) << DIGIT_W);
        end
    end

endmodule

// File: rtl/lut_multiplier_seq_ctrl.sv
// Sequencer computing a 32x32 unsigned product one multiplier digit per cycle.
// Optional EARLY_TERM_EN: leave RUN as soon as the remaining multiplier digits are zero.
module lut_multiplier_seq_ctrl
    import lut_multiplier_seq_ctrl_pkg::*;
(
    input  logic                clk_seq,
    input  logic                reset_seq,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [OPER_W-1:0]   operand_a,
    input  logic [OPER_W-1:0]   operand_b,
    output logic                busy,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [PROD_W-1:0]   result
);

    state_e             state_q, state_d;
    logic [OPER_W-1:0]  a_q, a_d;
    logic [OPER_W-1:0]  b_q, b_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PART_W-1:0]  partial;
    logic [SH_W-1:0]    shamt;
    logic               last_digit;

    lut_multiplier_4b_cond u_lut (
        .resetn   (~reset_seq),
        .mcand    (a_q),
        .digit_lo (b_q[DIGIT_W-1:0]),
        .digit_hi ({DIGIT_W{1'b0}}),
        .product  (partial)
    );

    assign shamt = SH_W'(cnt_q) * SH_W'(DIGIT_W);

`ifdef EARLY_TERM_EN
    assign last_digit = (cnt_q == CNT_W'(N_DIGITS - 1)) || (b_q[OPER_W-1:DIGIT_W] == '0);
`else
    assign last_digit = (cnt_q == CNT_W'(N_DIGITS - 1));
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    state_d = StRun;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                acc_d = acc_q + (PROD_W'(partial) << shamt);
                b_d   = b_q >> DIGIT_W;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_seq) begin
        if (reset_seq) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign start_ready  = (state_q == StIdle);
    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
    assign result       = acc_q;

endmodule

// File: tb/tb_lut_multiplier_seq_ctrl.sv
// Directed bench for lut_multiplier_seq_ctrl; expected latencies follow EARLY_TERM_EN.
module tb_lut_multiplier_seq_ctrl;

    logic        clk_seq = 1'b0;
    logic        reset_seq;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

    lut_multiplier_seq_ctrl dut (
        .clk_seq      (clk_seq),
        .reset_seq    (reset_seq),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result)
    );

    always #5 clk_seq = ~clk_seq;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_seq);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for result_valid; optionally pulse a
    // second start with different operands while the first is running.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [63:0] exp, input bit pulse);
        int n;
        operand_a   = a;
        operand_b   = b;
        start_valid = 1'b1;
        chk({tag, "_start_ready"}, 64'(start_ready), 64'd1);
        tick();
        start_valid = 1'b0;
        operand_a   = $urandom;
        operand_b   = $urandom;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_not_ready"}, 64'(start_ready), 64'd0);
        n = 0;
        while (!result_valid && n < 40) begin
            if (pulse && n == 1) begin
                start_valid = 1'b1;
                operand_a   = 32'd9;
                operand_b   = 32'd9;
                chk({tag, "_pulse_ready"}, 64'(start_ready), 64'd0);
            end
            tick();
            start_valid = 1'b0;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat));
        chk({tag, "_result"}, result, exp);
    endtask

    initial begin
        int  lat_ff, lat_3x5, lat_pulse, lat_7x6, lat_big;
        bit  seen_valid;
`ifdef EARLY_TERM_EN
        lat_ff = 8; lat_3x5 = 1; lat_pulse = 2; lat_7x6 = 1; lat_big = 5;
`else
        lat_ff = 8; lat_3x5 = 8; lat_pulse = 8; lat_7x6 = 8; lat_big = 8;
`endif
        // 1: reset with random inputs
        reset_seq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_valid  = 1'($urandom);
            result_ready = 1'($urandom);
            operand_a    = $urandom;
            operand_b    = $urandom;
            tick();
        end
        chk("rst_start_ready", 64'(start_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        reset_seq    = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b1;
        tick();

        // 2: all-ones operands
        do_op("ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat_ff, 64'hFFFF_FFFE_0000_0001, 1'b0);
        tick();
        chk("ff_idle_ready", 64'(start_ready), 64'd1);
        chk("ff_idle_valid", 64'(result_valid), 64'd0);

        // 3: small operands
        do_op("3x5", 32'd3, 32'd5, lat_3x5, 64'd15, 1'b0);
        tick();
        chk("3x5_idle_ready", 64'(start_ready), 64'd1);

        // 5: start pulse during RUN is ignored
        do_op("pulse", 32'd100, 32'd200, lat_pulse, 64'd20000, 1'b1);
        tick();
        chk("pulse_idle_ready", 64'(start_ready), 64'd1);

        // 6: reset on RUN cycle 4
        operand_a   = 32'hFFFF_FFFF;
        operand_b   = 32'hFFFF_FFFF;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (3) tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset_seq = 1'b1;
        tick();
        reset_seq = 1'b0;
        chk("abort_start_ready", 64'(start_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(result_valid), 64'd0);
        chk("abort_result", result, 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result_valid || busy) seen_valid = 1'b1;
        end
        chk("abort_no_result", 64'(seen_valid), 64'd0);
        do_op("7x6", 32'd7, 32'd6, lat_7x6, 64'd42, 1'b0);
        tick();

        // 4 + 7: higher digit only, consumer stalls 5 cycles
        result_ready = 1'b0;
        do_op("big", 32'h1234_5678, 32'h0001_0000, lat_big, 64'h0000_1234_5678_0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(result_valid), 64'd1);
            chk("stall_result", result, 64'h0000_1234_5678_0000);
        end
        result_ready = 1'b1;
        tick();
        chk("release_ready", 64'(start_ready), 64'd1);
        chk("release_valid", 64'(result_valid), 64'd0);
        chk("release_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
